// File: rtl/fixed_act_requant_stage.sv
// Per-lane Q(IN_W,IN_F) -> Q(OUT_W,OUT_F) requantizer with round-half-up, saturation,
// a 2-entry skid buffer and tensor last tagging. Optional clip counter: FIXED_ACT_REQUANT_SAT_COUNT_EN.
module fixed_act_requant_stage #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 4,
    parameter int DATA_OUT_0_PRECISION_1      = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_last
`ifdef FIXED_ACT_REQUANT_SAT_COUNT_EN
    ,
    output logic [15:0]                       sat_count
`endif
);

    localparam int IN_W  = DATA_IN_0_PRECISION_0;
    localparam int IN_F  = DATA_IN_0_PRECISION_1;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int OUT_F = DATA_OUT_0_PRECISION_1;
    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int BEATS = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                           (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int D     = IN_F - OUT_F;
    // Intermediate must hold the rounding carry (D>0) or the left-shifted value (D<0).
    localparam int WA    = (D < 0) ? IN_W - D : IN_W + 1;
    localparam int WW    = (WA > OUT_W + 1) ? WA : OUT_W + 1;

    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [OUT_W-1:0] w_q        [N];
    logic [OUT_W-1:0] r_outData  [N];
    logic [OUT_W-1:0] r_skidData [N];
    logic [N-1:0]     w_clip;
    logic             r_outLast;
    logic             r_skidLast;
    logic             r_ready;
    logic [CW-1:0]    r_count;
    logic             w_valid;
    logic             w_inXfer;
    logic             w_outXfer;
    logic             w_tagLast;
    logic             w_loadOutNew;
    logic             w_loadOutSkid;
    logic             w_loadSkid;

    genvar g;
    for (g = 0; g < N; g++) begin : g_lane
        logic signed [WW-1:0] w_ext;
        logic signed [WW-1:0] w_scaled;

        assign w_ext = {{(WW-IN_W){data_in_0[g][IN_W-1]}}, data_in_0[g]};

        if (D > 0) begin : g_round
            localparam logic signed [WW-1:0] HALF = {{(WW-1){1'b0}}, 1'b1} << (D - 1);
            assign w_scaled = (w_ext + HALF) >>> D;
        end else if (D == 0) begin : g_pass
            assign w_scaled = w_ext;
        end else begin : g_shl
            assign w_scaled = w_ext <<< (-D);
        end

        assign w_clip[g] = (w_scaled > SAT_MAX) || (w_scaled < SAT_MIN);
        assign w_q[g]    = (w_scaled > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                           (w_scaled < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                                  w_scaled[OUT_W-1:0];
    end

    assign w_valid   = (r_state != EMPTY);
    assign w_inXfer  = data_in_0_valid && r_ready;
    assign w_outXfer = w_valid && data_out_0_ready;
    assign w_tagLast = (r_count == CW'(BEATS - 1));

    always_comb begin
        w_nextState   = r_state;
        w_loadOutNew  = 1'b0;
        w_loadOutSkid = 1'b0;
        w_loadSkid    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_inXfer) begin
                    w_nextState  = ONE;
                    w_loadOutNew = 1'b1;
                end
            end
            ONE: begin
                if (w_inXfer && !w_outXfer) begin
                    w_nextState = FULL;
                    w_loadSkid  = 1'b1;
                end else if (w_inXfer && w_outXfer) begin
                    w_loadOutNew = 1'b1;
                end else if (w_outXfer) begin
                    w_nextState = EMPTY;
                end
            end
            FULL: begin
                // Ready is low here, so only the drain of the output register can happen.
                if (w_outXfer) begin
                    w_nextState   = ONE;
                    w_loadOutSkid = 1'b1;
                end
            end
            default: w_nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_ready <= (w_nextState != FULL);
            if (w_inXfer) begin
                r_count <= w_tagLast ? '0 : r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outLast  <= 1'b0;
            r_skidLast <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_outData[i]  <= '0;
                r_skidData[i] <= '0;
            end
        end else begin
            if (w_loadOutNew) begin
                r_outData <= w_q;
                r_outLast <= w_tagLast;
            end else if (w_loadOutSkid) begin
                r_outData <= r_skidData;
                r_outLast <= r_skidLast;
            end
            if (w_loadSkid) begin
                r_skidData <= w_q;
                r_skidLast <= w_tagLast;
            end
        end
    end

    assign data_out_0       = r_outData;
    assign data_out_0_valid = w_valid;
    assign data_out_0_last  = r_outLast && w_valid;
    assign data_in_0_ready  = r_ready;

`ifdef FIXED_ACT_REQUANT_SAT_COUNT_EN
    logic [15:0] r_satCount;
    logic [16:0] w_clipNum;
    logic [16:0] w_satSum;

    always_comb begin
        w_clipNum = '0;
        for (int i = 0; i < N; i++) begin
            w_clipNum = w_clipNum + 17'(w_clip[i]);
        end
        w_satSum = {1'b0, r_satCount} + w_clipNum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_satCount <= '0;
        end else if (w_inXfer) begin
            r_satCount <= w_satSum[16] ? 16'hFFFF : w_satSum[15:0];
        end
    end

    assign sat_count = r_satCount;
`else
    logic w_unusedClip;
    assign w_unusedClip = ^w_clip;
`endif

endmodule

// File: tb/tb_fixed_act_requant_stage.sv
// Directed bench for fixed_act_requant_stage: Q8.4 -> Q4.1, two lanes, 4-beat tensors.
// Covers rounding, saturation, skid backpressure, reset while full and tensor framing.
module tb_fixed_act_requant_stage;

    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int N     = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  dIn  [N];
    logic             inValid;
    logic             inReady;
    logic [OUT_W-1:0] dOut [N];
    logic             outValid;
    logic             outReady;
    logic             outLast;
`ifdef FIXED_ACT_REQUANT_SAT_COUNT_EN
    logic [15:0]      satCount;
`endif

    int total = 0;
    int bad   = 0;

    fixed_act_requant_stage #(
        .DATA_IN_0_PRECISION_0      (8),
        .DATA_IN_0_PRECISION_1      (4),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(8),
        .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
        .DATA_IN_0_PARALLELISM_DIM_0(2),
        .DATA_IN_0_PARALLELISM_DIM_1(1),
        .DATA_OUT_0_PRECISION_0     (4),
        .DATA_OUT_0_PRECISION_1     (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_0       (dIn),
        .data_in_0_valid (inValid),
        .data_in_0_ready (inReady),
        .data_out_0      (dOut),
        .data_out_0_valid(outValid),
        .data_out_0_ready(outReady),
        .data_out_0_last (outLast)
`ifdef FIXED_ACT_REQUANT_SAT_COUNT_EN
        ,
        .sat_count       (satCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one beat and hold it until the stage accepts it (bounded).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        int waitCyc;
        waitCyc = 0;
        dIn[0]  = a;
        dIn[1]  = b;
        inValid = 1'b1;
        while (!inReady && waitCyc < 20) begin
            tick();
            waitCyc++;
        end
        checkOutput("accept_in_time", 32'(waitCyc < 20), 32'd1);
        tick();
        inValid = 1'b0;
    endtask

    // Reference: round((x/16)*2) half-up, via floor division of (x+4) by 8, then clamp.
    function automatic logic [3:0] modelQ(input logic [7:0] x);
        int v;
        int n;
        int q;
        v = int'($signed(x));
        n = v + 4;
        q = n / 8;
        if (n < 0 && (n % 8) != 0) q = q - 1;
        if (q > 7) q = 7;
        if (q < -8) q = -8;
        return q[3:0];
    endfunction

    function automatic logic [7:0] pattern(input int k, input int lane);
        return 8'(k * 37 + lane * 91 + 5);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int outCnt;
        int sentIdx;
        int cyc;

        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        dIn[0]   = '0;
        dIn[1]   = '0;
        tick();
        tick();
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_last", 32'(outLast), 32'd0);
        checkOutput("rst_ready", 32'(inReady), 32'd1);
        checkOutput("rst_d0", 32'(dOut[0]), 32'h0);
        checkOutput("rst_d1", 32'(dOut[1]), 32'h0);
        rst = 1'b0;
        tick();

        // Arithmetic with the consumer always ready; beats 0..5 of the tensor stream.
        outReady = 1'b1;
        applyStimulus(8'h17, 8'h7F);
        checkOutput("b0_valid", 32'(outValid), 32'd1);
        checkOutput("b0_round_1p4375", 32'(dOut[0]), 32'h3);
        checkOutput("b0_pos_sat", 32'(dOut[1]), 32'h7);
        checkOutput("b0_last", 32'(outLast), 32'd0);
        applyStimulus(8'h80, 8'hF8);
        checkOutput("b1_neg_sat", 32'(dOut[0]), 32'h8);
        checkOutput("b1_neg_half", 32'(dOut[1]), 32'hF);
`ifdef FIXED_ACT_REQUANT_SAT_COUNT_EN
        checkOutput("sat_after_b1", 32'(satCount), 32'd2);
`endif
        applyStimulus(8'hF3, 8'h0C);
        checkOutput("b2_neg_round", 32'(dOut[0]), 32'hE);
        checkOutput("b2_0p75", 32'(dOut[1]), 32'h2);
        checkOutput("b2_last", 32'(outLast), 32'd0);
        applyStimulus(8'h04, 8'hFC);
        checkOutput("b3_half_up", 32'(dOut[0]), 32'h1);
        checkOutput("b3_neg_quarter", 32'(dOut[1]), 32'h0);
        checkOutput("b3_last", 32'(outLast), 32'd1);
        applyStimulus(8'h3C, 8'hC4);
        checkOutput("b4_pos_sat", 32'(dOut[0]), 32'h7);
        checkOutput("b4_neg_inrange", 32'(dOut[1]), 32'h9);
        checkOutput("b4_last", 32'(outLast), 32'd0);
        applyStimulus(8'hC0, 8'h3B);
        checkOutput("b5_min_exact", 32'(dOut[0]), 32'h8);
        checkOutput("b5_max_exact", 32'(dOut[1]), 32'h7);
`ifdef FIXED_ACT_REQUANT_SAT_COUNT_EN
        checkOutput("sat_after_b5", 32'(satCount), 32'd3);
`endif
        tick();
        checkOutput("drain_valid", 32'(outValid), 32'd0);

        // Backpressure: beats 6 and 7 fill output and skid, beat 8 must wait.
        outReady = 1'b0;
        applyStimulus(8'h10, 8'h20);
        applyStimulus(8'h30, 8'hE0);
        dIn[0]  = 8'h08;
        dIn[1]  = 8'hF0;
        inValid = 1'b1;
        tick();
        checkOutput("bp_ready_low", 32'(inReady), 32'd0);
        checkOutput("bp_valid", 32'(outValid), 32'd1);
        checkOutput("bp_d0", 32'(dOut[0]), 32'h2);
        checkOutput("bp_d1", 32'(dOut[1]), 32'h4);
        tick();
        tick();
        checkOutput("bp_hold_d0", 32'(dOut[0]), 32'h2);
        checkOutput("bp_hold_d1", 32'(dOut[1]), 32'h4);
        checkOutput("bp_hold_last", 32'(outLast), 32'd0);
        checkOutput("bp_hold_ready", 32'(inReady), 32'd0);
        outReady = 1'b1;
        tick();
        checkOutput("skid_d0", 32'(dOut[0]), 32'h6);
        checkOutput("skid_d1", 32'(dOut[1]), 32'hC);
        checkOutput("skid_last", 32'(outLast), 32'd1);
        checkOutput("skid_ready_back", 32'(inReady), 32'd1);
        tick();
        inValid = 1'b0;
        checkOutput("b8_d0", 32'(dOut[0]), 32'h1);
        checkOutput("b8_d1", 32'(dOut[1]), 32'hE);
        checkOutput("b8_last", 32'(outLast), 32'd0);
        tick();
        checkOutput("bp_drained", 32'(outValid), 32'd0);

        // Reset while both entries are occupied.
        outReady = 1'b0;
        applyStimulus(8'h11, 8'h22);
        applyStimulus(8'h33, 8'h44);
        checkOutput("full_before_rst", 32'(inReady), 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("midrst_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_ready", 32'(inReady), 32'd1);
        checkOutput("midrst_d0", 32'(dOut[0]), 32'h0);
`ifdef FIXED_ACT_REQUANT_SAT_COUNT_EN
        checkOutput("midrst_sat", 32'(satCount), 32'd0);
`endif
        rst = 1'b0;

        // Framing: 12 beats under random ready; last on output beats 3, 7 and 11.
        outCnt  = 0;
        sentIdx = 0;
        cyc     = 0;
        while (outCnt < 12 && cyc < 400) begin
            if (sentIdx < 12) begin
                dIn[0]  = pattern(sentIdx, 0);
                dIn[1]  = pattern(sentIdx, 1);
                inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            outReady = 1'($urandom_range(0, 1));
            if (outValid && outReady) begin
                checkOutput("frame_d0", 32'(dOut[0]), 32'(modelQ(pattern(outCnt, 0))));
                checkOutput("frame_d1", 32'(dOut[1]), 32'(modelQ(pattern(outCnt, 1))));
                checkOutput("frame_last", 32'(outLast), 32'((outCnt % 4) == 3));
                outCnt++;
            end
            if (inValid && inReady) sentIdx++;
            tick();
            cyc++;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("frame_count", 32'(outCnt), 32'd12);
        tick();
        checkOutput("frame_idle", 32'(outValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
